// File: rtl/serial_parity_rx.sv
// ----------------------------------------------------------------------------
// serial_parity_rx
//
// Bit-serial frame receiver for the parity detector path. A frame is one
// start bit (0), N data bits LSB first, one parity bit and one stop bit (1).
// The receiver assembles the word, counts its ones, checks the parity bit
// against the selected parity sense and presents the result with a
// one-cycle out_valid strobe. serial_in is only looked at on cycles where
// bit_valid is high; every other cycle holds state (apart from the
// out_valid clear).
//
// Parameters:
//   N   data bits per frame (N >= 2)
//   CW  width of ones_cnt, 2**CW > N
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bit_valid   qualifies serial_in
//   serial_in   serial data line
//   odd_mode    0 = even parity, 1 = odd parity (sampled on the parity bit)
//   data_out    assembled word, bit 0 = first data bit received
//   ones_cnt    number of ones in data_out
//   out_valid   one-cycle pulse when the result outputs update
//   parity_err  parity mismatch on the last frame
//   frame_err   stop bit was 0 on the last frame
//   busy        receiver is inside a frame (state != IDLE)
//   err_cnt     (only with SERIAL_PARITY_ERR_CNT_EN) saturating count of
//               frames reported with parity_err or frame_err
//
// Optional feature macro: SERIAL_PARITY_ERR_CNT_EN
// ----------------------------------------------------------------------------
module serial_parity_rx #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bit_valid,
    input  logic          serial_in,
    input  logic          odd_mode,
    output logic [N-1:0]  data_out,
    output logic [CW-1:0] ones_cnt,
    output logic          out_valid,
    output logic          parity_err,
    output logic          frame_err,
    output logic          busy
`ifdef SERIAL_PARITY_ERR_CNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t          state_q,      state_d;
    logic [N-1:0]    shift_q,      shift_d;
    logic [IW-1:0]   idx_q,        idx_d;
    logic            run_par_q,    run_par_d;
    logic [CW-1:0]   run_cnt_q,    run_cnt_d;
    logic            perr_q,       perr_d;
    logic [N-1:0]    data_out_q,   data_out_d;
    logic [CW-1:0]   ones_cnt_q,   ones_cnt_d;
    logic            out_valid_q,  out_valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q,  frame_err_d;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0]      err_cnt_q,    err_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        run_par_d    = run_par_q;
        run_cnt_d    = run_cnt_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        ones_cnt_d   = ones_cnt_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        // out_valid is a pulse: it drops on the next cycle whatever bit_valid does
        out_valid_d  = 1'b0;
`ifdef SERIAL_PARITY_ERR_CNT_EN
        err_cnt_d    = err_cnt_q;
`endif

        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    // A 1 on the line is idle; a 0 is the start bit
                    if (!serial_in) begin
                        state_d   = DATA;
                        idx_d     = '0;
                        shift_d   = '0;
                        run_par_d = 1'b0;
                        run_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d[idx_q] = serial_in;
                    run_par_d      = run_par_q ^ serial_in;
                    run_cnt_d      = run_cnt_q + CW'(serial_in);
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                PARITY: begin
                    // Even mode wants data^parity == 0, odd mode wants 1
                    perr_d  = run_par_q ^ serial_in ^ odd_mode;
                    state_d = STOP;
                end
                STOP: begin
                    data_out_d   = shift_q;
                    ones_cnt_d   = run_cnt_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ~serial_in;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
`ifdef SERIAL_PARITY_ERR_CNT_EN
                    if ((perr_q || !serial_in) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            run_par_q    <= 1'b0;
            run_cnt_q    <= '0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            ones_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERIAL_PARITY_ERR_CNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            run_par_q    <= run_par_d;
            run_cnt_q    <= run_cnt_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            ones_cnt_q   <= ones_cnt_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
`ifdef SERIAL_PARITY_ERR_CNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign ones_cnt   = ones_cnt_q;
    assign out_valid  = out_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);
`ifdef SERIAL_PARITY_ERR_CNT_EN
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// ----------------------------------------------------------------------------
// Testbench for serial_parity_rx (N=4, CW=3). Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the rising edge the DUT uses.
// ----------------------------------------------------------------------------
module tb_serial_parity_rx;

    logic       clk;
    logic       rst;
    logic       bit_valid;
    logic       serial_in;
    logic       odd_mode;
    logic [3:0] data_out;
    logic [2:0] ones_cnt;
    logic       out_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Pulse monitor: counts out_valid cycles and records what they carried
    int         pulse_cnt = 0;
    logic [3:0] got_data_q[$];
    logic [2:0] got_ones_q[$];
    logic       got_perr_q[$];
    logic       got_ferr_q[$];

    serial_parity_rx #(.N(4), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .odd_mode   (odd_mode),
        .data_out   (data_out),
        .ones_cnt   (ones_cnt),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef SERIAL_PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            pulse_cnt++;
            got_data_q.push_back(data_out);
            got_ones_q.push_back(ones_cnt);
            got_perr_q.push_back(parity_err);
            got_ferr_q.push_back(frame_err);
        end
    end

    // ---------------- drivers ----------------
    // Called at a falling edge; holds the bit for one full cycle, then
    // leaves bit_valid low for 'gap' further cycles.
    task automatic strobe(input logic b, input int gap);
        bit_valid = 1'b1;
        serial_in = b;
        @(negedge clk);
        bit_valid = 1'b0;
        serial_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par,
                              input logic stp, input int gap);
        strobe(1'b0, gap);
        for (int i = 0; i < 4; i++) strobe(d[i], gap);
        strobe(par, gap);
        strobe(stp, gap);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        bit_valid = 1'b0;
        serial_in = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_monitor();
        pulse_cnt = 0;
        got_data_q.delete();
        got_ones_q.delete();
        got_perr_q.delete();
        got_ferr_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(2);
        clear_monitor();
        tests_run++;
        if ({data_out, ones_cnt, out_valid, parity_err, frame_err, busy} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got data=%0d ones=%0d v=%0b perr=%0b ferr=%0b busy=%0b, expected all 0",
                     data_out, ones_cnt, out_valid, parity_err, frame_err, busy);
        end
`ifdef SERIAL_PARITY_ERR_CNT_EN
        tests_run++;
        if (err_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            serial_in = 1'b1;
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_busy[%0d]: got %0b expected 0", i, busy);
            end
        end
        bit_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (pulse_cnt !== 0 || data_out !== 4'd0 || ones_cnt !== 3'd0) begin
            tests_failed++;
            $display("FAIL idle_no_pulse: got pulses=%0d data=%0d ones=%0d expected 0/0/0",
                     pulse_cnt, data_out, ones_cnt);
        end
    endtask

    task automatic test_good_even();
        clear_monitor();
        odd_mode = 1'b0;
        send_frame(4'b1101, 1'b1, 1'b1, 0);
        // stop strobe has just been taken: out_valid is visible now
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL good_latency: out_valid got %0b expected 1", out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_pulse_width: out_valid got %0b expected 0", out_valid);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (pulse_cnt !== 1 || data_out !== 4'd13 || ones_cnt !== 3'd3 ||
            parity_err !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_even: got pulses=%0d data=%0d ones=%0d perr=%0b ferr=%0b expected 1/13/3/0/0",
                     pulse_cnt, data_out, ones_cnt, parity_err, frame_err);
        end
    endtask

    task automatic test_parity_err();
        clear_monitor();
        odd_mode = 1'b0;
        send_frame(4'b0011, 1'b1, 1'b1, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (pulse_cnt !== 1 || data_out !== 4'd3 || ones_cnt !== 3'd2 ||
            parity_err !== 1'b1 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_err_even: got pulses=%0d data=%0d ones=%0d perr=%0b ferr=%0b expected 1/3/2/1/0",
                     pulse_cnt, data_out, ones_cnt, parity_err, frame_err);
        end
        // Same frame in odd mode; odd_mode wiggles during data bits, only
        // the value present on the parity strobe should matter.
        clear_monitor();
        odd_mode = 1'b0;
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        odd_mode = 1'b1;
        strobe(1'b1, 0);
        odd_mode = 1'b0;
        strobe(1'b0, 0);
        strobe(1'b0, 0);
        odd_mode = 1'b1;
        strobe(1'b1, 0);
        odd_mode = 1'b0;
        strobe(1'b1, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (pulse_cnt !== 1 || data_out !== 4'd3 || ones_cnt !== 3'd2 || parity_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_ok_odd: got pulses=%0d data=%0d ones=%0d perr=%0b expected 1/3/2/0",
                     pulse_cnt, data_out, ones_cnt, parity_err);
        end
    endtask

    task automatic test_frame_err_gapped();
        clear_monitor();
        odd_mode = 1'b0;
        send_frame(4'b1111, 1'b0, 1'b0, 3);
        repeat (3) @(negedge clk);
        tests_run++;
        if (pulse_cnt !== 1 || data_out !== 4'd15 || ones_cnt !== 3'd4 ||
            parity_err !== 1'b0 || frame_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_err_gapped: got pulses=%0d data=%0d ones=%0d perr=%0b ferr=%0b expected 1/15/4/0/1",
                     pulse_cnt, data_out, ones_cnt, parity_err, frame_err);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_err_busy: got %0b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_monitor();
        odd_mode = 1'b0;
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b1, 0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_frame_busy: got %0b expected 1", busy);
        end
        do_reset(1);
        tests_run++;
        if (busy !== 1'b0 || data_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_frame_abort: got busy=%0b data=%0d expected 0/0", busy, data_out);
        end
        send_frame(4'b1000, 1'b1, 1'b1, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (pulse_cnt !== 1 || data_out !== 4'd8 || ones_cnt !== 3'd1 || parity_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_frame_recover: got pulses=%0d data=%0d ones=%0d perr=%0b expected 1/8/1/0",
                     pulse_cnt, data_out, ones_cnt, parity_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vec [10];
        logic       bad [10];
        logic [3:0] exp_q[$];
        logic [2:0] exp_ones_q[$];
        logic       exp_perr_q[$];
        vec = '{4'h5, 4'hA, 4'h7, 4'h0, 4'hF, 4'h9, 4'h1, 4'hE, 4'h3, 4'hC};
        bad = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(1);
        clear_monitor();
        odd_mode = 1'b0;
        for (int f = 0; f < 10; f++) begin
            logic [2:0] ones;
            ones = 3'd0;
            for (int j = 0; j < 4; j++) ones = ones + {2'b00, vec[f][j]};
            exp_q.push_back(vec[f]);
            exp_ones_q.push_back(ones);
            exp_perr_q.push_back(bad[f]);
            // even parity bit, flipped for the deliberately bad frames
            send_frame(vec[f], (^vec[f]) ^ bad[f], 1'b1, 0);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (pulse_cnt !== 10) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got %0d expected 10", pulse_cnt);
        end
        for (int f = 0; f < 10; f++) begin
            if (got_data_q.size() == 0) break;
            tests_run++;
            if (got_data_q[0] !== exp_q[0] || got_ones_q[0] !== exp_ones_q[0] ||
                got_perr_q[0] !== exp_perr_q[0] || got_ferr_q[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_frame[%0d]: got data=%0d ones=%0d perr=%0b ferr=%0b expected %0d/%0d/%0b/0",
                         f, got_data_q[0], got_ones_q[0], got_perr_q[0], got_ferr_q[0],
                         exp_q[0], exp_ones_q[0], exp_perr_q[0]);
            end
            void'(got_data_q.pop_front());
            void'(got_ones_q.pop_front());
            void'(got_perr_q.pop_front());
            void'(got_ferr_q.pop_front());
            void'(exp_q.pop_front());
            void'(exp_ones_q.pop_front());
            void'(exp_perr_q.pop_front());
        end
`ifdef SERIAL_PARITY_ERR_CNT_EN
        tests_run++;
        if (err_cnt !== 8'd3) begin
            tests_failed++;
            $display("FAIL b2b_err_cnt: got %0d expected 3", err_cnt);
        end
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        serial_in = 1'b1;
        odd_mode  = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_even();
        test_parity_err();
        test_frame_err_gapped();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net: the sequence is a few hundred cycles long
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
